// File: rtl/qrisc32_id.sv
// Decode stage: field split, 32x32 register file with write-through reads, load-use hazard detection.
// One-cycle latency to ex_*; pipe_stall holds outputs, new_address_valid flushes, hazard inserts a bubble.
module qrisc32_id (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic        pipe_stall,
  input  logic        new_address_valid,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [5:0]  ex_opcode,
  output logic [4:0]  ex_dst,
  output logic [31:0] ex_src1,
  output logic [31:0] ex_src2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic        hazard_stall
);

  localparam logic [5:0] OP_LOAD = 6'h01;

  logic [31:0] regs [32];
  logic [5:0]  opcode;
  logic [4:0]  dst;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [31:0] imm;
  logic [31:0] src1_val;
  logic [31:0] src2_val;

  assign opcode = instruction[31:26];
  assign dst    = instruction[25:21];
  assign src1   = instruction[20:16];
  assign src2   = instruction[15:11];
  assign imm    = {{16{instruction[15]}}, instruction[15:0]};

  // Bypass the write-back port so a same-cycle write is not missed.
  always_comb begin
    src1_val = regs[src1];
    src2_val = regs[src2];
    if (wb_valid && (wb_reg == src1)) src1_val = wb_data;
    if (wb_valid && (wb_reg == src2)) src2_val = wb_data;
  end

  // A bubble in EX has ex_valid=0, so it can never raise a hazard.
  assign hazard_stall = !reset && !new_address_valid && !pipe_stall &&
                        ex_valid && (ex_opcode == OP_LOAD) &&
                        ((ex_dst == src1) || (ex_dst == src2));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_dst    <= '0;
      ex_src1   <= '0;
      ex_src2   <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else if (new_address_valid) begin
      ex_valid <= 1'b0;
    end else if (pipe_stall) begin
      ex_valid <= ex_valid;
    end else if (hazard_stall) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid  <= (instruction != 32'h0);
      ex_opcode <= opcode;
      ex_dst    <= dst;
      ex_src1   <= src1_val;
      ex_src2   <= src2_val;
      ex_imm    <= imm;
      ex_pc     <= pc;
    end
  end

endmodule

// File: tb/tb_qrisc32_id.sv
// Randomized + directed bench for qrisc32_id with a queue-based scoreboard and reference model.
module tb_qrisc32_id;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic [31:0] pc = '0;
  logic        pipe_stall = 1'b0;
  logic        new_address_valid = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [4:0]  ex_dst;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;
  logic        hazard_stall;

  qrisc32_id dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pc(pc),
    .pipe_stall(pipe_stall), .new_address_valid(new_address_valid),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dst(ex_dst),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic        hz;
    logic        v;
    logic [5:0]  op;
    logic [4:0]  dst;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] imm;
    logic [31:0] pc;
  } rec_t;

  rec_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: architectural registers plus the decoded EX view.
  logic [31:0] m_regs [32];
  rec_t        m;
  logic        last_hz;

  function automatic logic [31:0] mk(input int op, input int d, input int a, input int b, input int im);
    logic [31:0] w;
    w = '0;
    w[31:26] = op[5:0];
    w[25:21] = d[4:0];
    w[20:16] = a[4:0];
    w[15:0]  = im[15:0];
    if (b >= 0) w[15:11] = b[4:0];
    return w;
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic st,
                       input logic wbv, input logic [4:0] wbr, input logic [31:0] wbd,
                       input logic [31:0] ins, input logic [31:0] pcv, input logic chk);
    rec_t r;
    logic hz;
    @(negedge clk);
    reset = rst; new_address_valid = fl; pipe_stall = st;
    wb_valid = wbv; wb_reg = wbr; wb_data = wbd;
    instruction = ins; pc = pcv;
    hz = !rst && !fl && !st && m.v && (m.op == 6'h01) &&
         ((m.dst == ins[20:16]) || (m.dst == ins[15:11]));
    r = m;
    r.chk = chk;
    r.hz = hz;
    exp_q.push_back(r);
    last_hz = hz;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m = '0;
    end else begin
      if (wbv) m_regs[wbr] = wbd;
      if (fl) m.v = 1'b0;
      else if (st) m.v = m.v;
      else if (hz) m.v = 1'b0;
      else begin
        m.v   = (ins != 0);
        m.op  = ins[31:26];
        m.dst = ins[25:21];
        m.s1  = m_regs[ins[20:16]];
        m.s2  = m_regs[ins[15:11]];
        m.imm = {{16{ins[15]}}, ins[15:0]};
        m.pc  = pcv;
      end
    end
  endtask

  task automatic go(input logic [31:0] ins, input logic [31:0] pcv);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, ins, pcv, 1'b1);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    #2;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cmp("hazard_stall", {31'b0, hazard_stall}, {31'b0, r.hz});
      if (r.chk) begin
        cmp("ex_valid", {31'b0, ex_valid}, {31'b0, r.v});
        cmp("ex_opcode", {26'b0, ex_opcode}, {26'b0, r.op});
        cmp("ex_dst", {27'b0, ex_dst}, {27'b0, r.dst});
        cmp("ex_src1", ex_src1, r.s1);
        cmp("ex_src2", ex_src2, r.s2);
        cmp("ex_imm", ex_imm, r.imm);
        cmp("ex_pc", ex_pc, r.pc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    m = '0;
    last_hz = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 32'h0, 32'h0, 1'b1);
    go(32'h0, 32'h4);

    // Write-through of R3, then sign extension and nop.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, mk(2, 1, 3, 0, 0), 32'h100, 1'b1);
    go(mk(3, 2, 3, -1, 16'h8000), 32'h104);
    go(mk(3, 2, 0, -1, 16'h7FFF), 32'h108);
    go(32'h0, 32'h10C);

    // Load-use: consumer held for one bubble, then issues.
    go(mk(1, 5, 3, -1, 16'h0010), 32'h110);
    go(mk(4, 6, 0, 5, 0), 32'h114);
    go(mk(4, 6, 0, 5, 0), 32'h114);
    go(mk(4, 6, 0, 1, 0), 32'h118);

    // Flush, and flush overriding stall.
    go(mk(7, 2, 1, 2, 16'h1234), 32'h200);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, mk(7, 3, 1, 2, 0), 32'h204, 1'b1);
    go(mk(7, 3, 1, 2, 16'h55), 32'h208);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, mk(7, 4, 1, 2, 0), 32'h20C, 1'b1);

    // Hold for three cycles while R7 is written, then read R7.
    go(mk(9, 8, 3, 1, 16'h0ABC), 32'h300);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h12, mk(9, 1, 7, 7, 0), 32'h304, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, mk(9, 1, 7, 7, 0), 32'h304, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, mk(9, 1, 7, 7, 0), 32'h304, 1'b1);
    go(mk(9, 1, 7, 7, 0), 32'h304);

    // Reset during a load-use hazard cycle; write-back in that cycle is dropped.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h55, 32'h0, 32'h400, 1'b1);
    go(mk(1, 5, 0, -1, 0), 32'h404);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h77, mk(4, 2, 5, 0, 0), 32'h408, 1'b1);
    go(mk(4, 2, 5, 5, 0), 32'h40C);
    go(mk(4, 2, 5, 5, 0), 32'h410);

    // Randomized traffic; the instruction is held after a hazard, as IF would.
    ins = 32'h0;
    for (int n = 0; n < 400; n++) begin
      logic rst, fl, st, wbv;
      if (!last_hz || ins == 32'h0) begin
        if ($urandom_range(0, 99) < 12) ins = 32'h0;
        else ins = mk(($urandom_range(0, 1) != 0) ? 1 : int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
      end
      rst = ($urandom_range(0, 99) < 2);
      fl  = ($urandom_range(0, 99) < 10);
      st  = ($urandom_range(0, 99) < 15);
      wbv = ($urandom_range(0, 99) < 50);
      drive(rst, fl, st, wbv, 5'($urandom_range(0, 7)), $urandom, ins, $urandom, 1'b1);
    end
    go(32'h0, 32'h0);

    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
